// File: rtl/enigma_pkg.sv
// Shared constants, pass encodings and state type for the Enigma sequencer.
package enigma_pkg;

  localparam int LETTERS = 26;
  localparam int POS_W   = 6;

  // Lookup pass numbers; also the table select presented to the wiring ROM.
  localparam logic [2:0] PASS_R1F  = 3'd0;
  localparam logic [2:0] PASS_R2F  = 3'd1;
  localparam logic [2:0] PASS_R3F  = 3'd2;
  localparam logic [2:0] PASS_REFL = 3'd3;
  localparam logic [2:0] PASS_R3I  = 3'd4;
  localparam logic [2:0] PASS_R2I  = 3'd5;
  localparam logic [2:0] PASS_R1I  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

  // Advance a rotor position by one, wrapping 25 -> 0.
  function automatic logic [POS_W-1:0] inc26(input logic [POS_W-1:0] v);
    return (v == POS_W'(LETTERS - 1)) ? '0 : v + 1'b1;
  endfunction

  // Out-of-range start positions collapse to 0.
  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v);
    return (v < POS_W'(LETTERS)) ? v : '0;
  endfunction

endpackage

// File: rtl/mod26_addsub.sv
// Combinational (a + b) mod 26 or (a - b) mod 26 for operands in 0..25.
module mod26_addsub
  import enigma_pkg::*;
#(
  parameter bit SUB = 1'b0
) (
  input  logic [POS_W-1:0] a,
  input  logic [POS_W-1:0] b,
  output logic [POS_W-1:0] y
);

  logic [POS_W:0] sum;
  logic [POS_W:0] diff;

  // 7-bit sum/difference followed by a single conditional correction by 26.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    y    = '0;
    if (SUB) begin
      if (a < b) y = POS_W'(diff + (POS_W+1)'(LETTERS));
      else       y = diff[POS_W-1:0];
    end else begin
      if (sum >= (POS_W+1)'(LETTERS)) y = POS_W'(sum - (POS_W+1)'(LETTERS));
      else                            y = sum[POS_W-1:0];
    end
  end

endmodule

// File: rtl/enigma_cipher_ctrl.sv
// Enigma single-character sequencer: rotor stepping plus 7 time-shared lookups.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_IDLE   | waiting for a character or a start-position load
//   ST_LOOKUP | driving lookup pass 0..6 to the shared wiring table
//   ST_OUT    | ciphertext presented, waiting for the sink to accept it
module enigma_cipher_ctrl
  import enigma_pkg::*;
#(
  parameter int NOTCH1 = 16,
  parameter int NOTCH2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [POS_W-1:0] cfg_pos1,
  input  logic [POS_W-1:0] cfg_pos2,
  input  logic [POS_W-1:0] cfg_pos3,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] in_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] out_char,
  output logic             lk_req,
  output logic [2:0]       lk_sel,
  output logic [POS_W-1:0] lk_in,
  input  logic             lk_ack,
  input  logic [POS_W-1:0] lk_out,
  output logic [POS_W-1:0] rotor1_pos,
  output logic [POS_W-1:0] rotor2_pos,
  output logic [POS_W-1:0] rotor3_pos,
  output logic             busy
);

  state_t           state, next_state;
  logic [2:0]       pass;
  logic [POS_W-1:0] cur;
  logic [POS_W-1:0] off;
  logic [POS_W-1:0] res;
  logic             accept;
  logic             is_letter;
  logic             notch1_hit;
  logic             notch2_hit;

  assign is_letter  = (in_char < POS_W'(LETTERS));
  assign accept     = in_valid & in_ready;
  assign notch1_hit = (rotor1_pos == POS_W'(NOTCH1));
  assign notch2_hit = (rotor2_pos == POS_W'(NOTCH2));
  assign lk_sel     = pass;

  // Rotor offset for the current pass: forward 1,2,3, reflector 0, inverse 3,2,1.
  always_comb begin
    off = '0;
    case (pass)
      PASS_R1F, PASS_R1I: off = rotor1_pos;
      PASS_R2F, PASS_R2I: off = rotor2_pos;
      PASS_R3F, PASS_R3I: off = rotor3_pos;
      default:            off = '0;
    endcase
  end

  mod26_addsub #(.SUB(1'b0)) u_add (
    .a (cur),
    .b (off),
    .y (lk_in)
  );

  mod26_addsub #(.SUB(1'b1)) u_sub (
    .a (lk_out),
    .b (off),
    .y (res)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    lk_req     = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        busy     = 1'b0;
        in_ready = ~cfg_load;
        if (accept) next_state = is_letter ? ST_LOOKUP : ST_OUT;
      end
      ST_LOOKUP: begin
        lk_req = 1'b1;
        if (lk_ack && pass == PASS_R1I) next_state = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath: rotor positions, working letter, pass counter, ciphertext.
  // Positions only move on the accept edge, so all 7 passes see one setting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rotor1_pos <= '0;
      rotor2_pos <= '0;
      rotor3_pos <= '0;
      cur        <= '0;
      pass       <= PASS_R1F;
      out_char   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_load) begin
            rotor1_pos <= clamp_pos(cfg_pos1);
            rotor2_pos <= clamp_pos(cfg_pos2);
            rotor3_pos <= clamp_pos(cfg_pos3);
          end else if (accept) begin
            if (is_letter) begin
              rotor1_pos <= inc26(rotor1_pos);
              if (notch1_hit || notch2_hit) rotor2_pos <= inc26(rotor2_pos);
              if (notch2_hit)               rotor3_pos <= inc26(rotor3_pos);
              cur  <= in_char;
              pass <= PASS_R1F;
            end else begin
              out_char <= in_char;
            end
          end
        end
        ST_LOOKUP: begin
          if (lk_ack) begin
            cur <= res;
            if (pass == PASS_R1I) out_char <= res;
            else                  pass     <= pass + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_cipher_ctrl.sv
// Directed bench for enigma_cipher_ctrl with a behavioural lookup-table stub.
module tb_enigma_cipher_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cfg_load;
  logic [5:0] cfg_pos1, cfg_pos2, cfg_pos3;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_char;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_char;
  logic       lk_req;
  logic [2:0] lk_sel;
  logic [5:0] lk_in;
  logic       lk_ack;
  logic [5:0] lk_out;
  logic [5:0] rotor1_pos, rotor2_pos, rotor3_pos;
  logic       busy;

  logic       ack_en;
  logic       shift_mode;
  int         n_checks;
  int         n_fail;

  enigma_cipher_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_load   (cfg_load),
    .cfg_pos1   (cfg_pos1),
    .cfg_pos2   (cfg_pos2),
    .cfg_pos3   (cfg_pos3),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_char   (out_char),
    .lk_req     (lk_req),
    .lk_sel     (lk_sel),
    .lk_in      (lk_in),
    .lk_ack     (lk_ack),
    .lk_out     (lk_out),
    .rotor1_pos (rotor1_pos),
    .rotor2_pos (rotor2_pos),
    .rotor3_pos (rotor3_pos),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table stub: identity, or +1 mod 26 so every pass adds exactly one.
  always_comb begin
    lk_ack = lk_req & ack_en;
    if (shift_mode) lk_out = (lk_in == 6'd25) ? 6'd0 : lk_in + 6'd1;
    else            lk_out = lk_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [5:0] p1, input logic [5:0] p2, input logic [5:0] p3);
    cfg_load = 1'b1;
    cfg_pos1 = p1;
    cfg_pos2 = p2;
    cfg_pos3 = p3;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic accept_char(input logic [5:0] c);
    in_valid = 1'b1;
    in_char  = c;
    step();
    in_valid = 1'b0;
  endtask

  // Walk passes 0..6 with ack high; ends just after the edge completing pass 6.
  task automatic run_passes(input string tag);
    for (int k = 0; k < 7; k++) begin
      chk({tag, "_sel"}, lk_sel, k);
      chk({tag, "_req"}, lk_req, 1);
      chk({tag, "_ovld_lo"}, out_valid, 0);
      step();
    end
  endtask

  task automatic chk_pos(input string tag, input int p1, input int p2, input int p3);
    chk({tag, "_r1"}, rotor1_pos, p1);
    chk({tag, "_r2"}, rotor2_pos, p2);
    chk({tag, "_r3"}, rotor3_pos, p3);
  endtask

  logic [5:0] st_cfg [4][3];
  int         st_exp [4][3];

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    cfg_load   = 1'b0;
    cfg_pos1   = '0;
    cfg_pos2   = '0;
    cfg_pos3   = '0;
    in_valid   = 1'b0;
    in_char    = '0;
    out_ready  = 1'b0;
    ack_en     = 1'b1;
    shift_mode = 1'b0;

    st_cfg[0] = '{6'd16, 6'd0,  6'd0};  st_exp[0] = '{17, 1, 0};
    st_cfg[1] = '{6'd5,  6'd4,  6'd0};  st_exp[1] = '{6,  5, 1};
    st_cfg[2] = '{6'd16, 6'd25, 6'd0};  st_exp[2] = '{17, 0, 0};
    st_cfg[3] = '{6'd0,  6'd4,  6'd25}; st_exp[3] = '{1,  5, 0};

    // Reset values
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_ovld", out_valid, 0);
    chk("rst_lkreq", lk_req, 0);
    chk("rst_ochar", out_char, 0);
    chk_pos("rst", 0, 0, 0);
    #10;
    rst_n = 1'b1;
    #1;
    chk("rst_inrdy", in_ready, 1);
    step();

    // Letter 0 at 0,0,0
    accept_char(6'd0);
    chk_pos("t1", 1, 0, 0);
    chk("t1_busy", busy, 1);
    run_passes("t1");
    chk("t1_ovld", out_valid, 1);
    chk("t1_ochar", out_char, 0);
    chk("t1_busy_out", busy, 1);
    out_ready = 1'b1;
    step();
    chk("t1_ovld_done", out_valid, 0);
    chk("t1_busy_done", busy, 0);

    // Identity stub, cfg 3,0,0, letter 7; then back-to-back accept at E9
    load_cfg(6'd3, 6'd0, 6'd0);
    accept_char(6'd7);
    chk("t2_lkin0", lk_in, 11);
    run_passes("t2");
    chk("t2_ovld", out_valid, 1);
    chk("t2_ochar", out_char, 7);
    step();
    chk("t2_inrdy_e8", in_ready, 1);
    accept_char(6'd7);
    chk("t2_busy_e9", busy, 1);
    chk_pos("t2b", 5, 0, 0);
    run_passes("t2b");
    chk("t2b_ochar", out_char, 7);
    step();

    // Stepping and double-step
    for (int i = 0; i < 4; i++) begin
      load_cfg(st_cfg[i][0], st_cfg[i][1], st_cfg[i][2]);
      accept_char(6'd1);
      chk_pos($sformatf("step%0d", i), st_exp[i][0], st_exp[i][1], st_exp[i][2]);
      repeat (7) step();
      chk($sformatf("step%0d_ovld", i), out_valid, 1);
      step();
    end

    // +1 stub: 22 at cfg 20,10,5 -> positions 21,10,5, result 22+7 mod 26 = 3
    shift_mode = 1'b1;
    load_cfg(6'd20, 6'd10, 6'd5);
    accept_char(6'd22);
    chk_pos("t3", 21, 10, 5);
    chk("t3_lkin0", lk_in, 17);
    repeat (4) step();
    chk("t3_sel4", lk_sel, 4);
    chk("t3_lkin4", lk_in, 5);
    repeat (3) step();
    chk("t3_ovld", out_valid, 1);
    chk("t3_ochar", out_char, 3);
    step();

    // Backpressure: ack withheld 3 cycles on pass 3, out_ready low 5 cycles
    out_ready = 1'b0;
    load_cfg(6'd0, 6'd0, 6'd0);
    accept_char(6'd2);
    repeat (3) step();
    ack_en = 1'b0;
    chk("bp_sel3", lk_sel, 3);
    chk("bp_lkin3", lk_in, 5);
    in_valid = 1'b1;
    in_char  = 6'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_req", lk_req, 1);
      chk("bp_hold_sel", lk_sel, 3);
      chk("bp_hold_lkin", lk_in, 5);
      chk("bp_hold_inrdy", in_ready, 0);
    end
    ack_en = 1'b1;
    repeat (4) step();
    chk("bp_ovld", out_valid, 1);
    chk("bp_ochar", out_char, 9);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_ovld", out_valid, 1);
      chk("bp_out_ochar", out_char, 9);
      chk("bp_out_inrdy", in_ready, 0);
      chk_pos("bp_out", 1, 0, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_done_ovld", out_valid, 0);
    chk_pos("bp_done", 1, 0, 0);

    // Pass-through character
    accept_char(6'd40);
    chk("pt_ovld", out_valid, 1);
    chk("pt_ochar", out_char, 40);
    chk("pt_lkreq", lk_req, 0);
    chk_pos("pt", 1, 0, 0);
    step();
    chk("pt_idle", busy, 0);

    // cfg_load beats in_valid; out-of-range position loads 0
    cfg_load = 1'b1;
    cfg_pos1 = 6'd30;
    cfg_pos2 = 6'd2;
    cfg_pos3 = 6'd3;
    in_valid = 1'b1;
    in_char  = 6'd5;
    #1;
    chk("cfg_inrdy", in_ready, 0);
    step();
    cfg_load = 1'b0;
    in_valid = 1'b0;
    chk("cfg_busy", busy, 0);
    chk_pos("cfg", 0, 2, 3);

    // Reset mid-LOOKUP
    accept_char(6'd5);
    chk_pos("mid", 1, 2, 3);
    repeat (2) step();
    chk("mid_req", lk_req, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_lkreq", lk_req, 0);
    chk("mrst_ovld", out_valid, 0);
    chk("mrst_ochar", out_char, 0);
    chk_pos("mrst", 0, 0, 0);
    #3;
    rst_n = 1'b1;
    step();
    chk("mrst_inrdy", in_ready, 1);
    chk("mrst_ovld_after", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enigma_cipher_ctrl.md
# enigma_cipher_ctrl

Sequencer for one Enigma character encipherment. Accepts a letter index over a valid/ready handshake, applies the odometer stepping (fast, middle and slow rotors, with double-step), then time-shares one external substitution-table unit across the 7 lookup passes: three forward rotor passes, the reflector, and three inverse rotor passes. Sits between the keyboard/UART front end and the shared rotor-wiring ROM, and owns the live rotor positions.

## Interface
- `NOTCH1`, default 16: rotor-1 position ('Q') at which the step carries into rotor 2.
- `NOTCH2`, default 4: rotor-2 position ('E') at which rotor 2 and rotor 3 step (double-step).
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_load`  in  1  load start positions; honored only in IDLE.
- `cfg_pos1`, `cfg_pos2`, `cfg_pos3`  in  6 each  start positions, 0..25.
- `in_valid`  in  1  input character valid.
- `in_ready`  out  1  `IDLE & !cfg_load`.
- `in_char`  in  6  0..25 letter; 26..63 pass-through.
- `out_valid`  out  1  ciphertext valid; held until accepted.
- `out_ready`  in  1  sink ready.
- `out_char`  out  6  ciphertext.
- `lk_req`  out  1  lookup request; held until `lk_ack`.
- `lk_sel`  out  3  table select = pass number 0..6.
- `lk_in`  out  6  table address, 0..25.
- `lk_ack`  in  1  lookup done; `lk_out` valid in the same cycle.
- `lk_out`  in  6  table result, 0..25.
- `rotor1_pos`, `rotor2_pos`, `rotor3_pos`  out  6 each  live positions.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, LOOKUP, OUT.
- IDLE:
  - `cfg_load` loads each `cfg_posN`; any value >25 loads 0.
  - Otherwise an accepted letter (`in_valid & in_ready`) steps the rotors, latches `cur <= in_char`, sets `pass <= 0` and enters LOOKUP.
  - An accepted pass-through (>25) goes to OUT with `out_char = in_char`, no stepping.
- Stepping uses pre-step values, all updates applied on the same edge:
  - r1 always steps.
  - r2 steps if `r1 == NOTCH1` or `r2 == NOTCH2`.
  - r3 steps if `r2 == NOTCH2`.
  - Every rotor wraps 25 -> 0; r3 wraps freely.
- LOOKUP, pass p:
  - Offset: pos1, pos2, pos3 for p = 0, 1, 2; 0 for p = 3; pos3, pos2, pos1 for p = 4, 5, 6.
  - `lk_sel = p`; `lk_in = (cur + off) mod 26`, computed as a 7-bit sum with a conditional subtract of 26.
  - On `lk_ack`: `cur <= (lk_out - off) mod 26` (add 26 if `lk_out < off`).
  - p = 6 with ack: `out_char <= new cur` and enter OUT; otherwise `p++`.
- OUT: `out_valid` = 1. On `out_ready`, go to IDLE.
- `cfg_load` outside IDLE is ignored. `in_valid` while busy is not accepted.
- `lk_req` = 1 only in LOOKUP. `lk_sel` and `lk_in` are stable while `lk_req` is high.

## Timing
- Reset values:
  - State IDLE, pass 0, cur 0.
  - All positions 0.
  - `out_valid` 0, `out_char` 0, `lk_req` 0, `busy` 0.
  - `in_ready` 1 once `rst_n` is high.
- Reset mid-operation aborts immediately. There is no `out_valid` for the aborted character, and positions return to 0, not to the configured values.
- Letter accepted at edge E0, `lk_ack` tied high:
  - Pass k completes at edge E(k+1).
  - `out_valid` rises after E7.
  - With `out_ready` high, transfer occurs at E8 and the next accept at E9, giving 1 character per 9 cycles.
- Each `lk_ack` wait cycle adds one cycle.
- Pass-through: accept at E0, `out_valid` after E0.
- Positions change only at the accept edge, so they are stable for all 7 passes.

## Structure
- `enigma_pkg`:
  - `LETTERS = 26`, `POS_W = 6`.
  - Pass encodings: `PASS_R1F = 0` … `PASS_REFL = 3` … `PASS_R1I = 6`.
  - State enum.
- Sub-module `mod26_addsub`: combinational `(a ± b) mod 26` for 0..25 operands, instantiated twice (add for `lk_in`, subtract for the result).

## Test plan
- Reset, then letter 0 at positions 0,0,0 -> positions become 1,0,0; `lk_sel` runs 0..6; `busy` high until the OUT handshake.
- Identity stub (`lk_out = lk_in`, `lk_ack = 1`), cfg 3,0,0, `in_char = 7` -> pass-0 `lk_in = 11`; `out_char = 7`; `out_valid` after E7.
- Stepping, start positions -> result:
  - 16,0,0 -> 17,1,0.
  - 5,4,0 -> 6,5,1 (double-step).
  - 16,25,0 -> 17,0,0.
  - 0,4,25 -> 1,5,0.
- Backpressure: `out_ready` low for 5 cycles, and `lk_ack` delayed 3 cycles on pass 3 -> `out_char` is held, `in_ready` stays 0, and there is no second accept.
- `in_char = 40` -> `out_char = 40` one cycle later, positions unchanged, no `lk_req`.
- `cfg_load` with `in_valid` in IDLE -> cfg loaded, char not accepted. `cfg_pos1 = 30` -> loads 0. `rst_n` low mid-LOOKUP -> all outputs at reset values.
